// File: rtl/jtvigil_obj_lbuf.sv
// Double-buffered object line buffer: one bank is drawn while the other is read out and erased.
// Optional macro JTVIGIL_LBUF_PRIO_EN switches draw writes from last-write-wins to first-write-wins.
module jtvigil_obj_lbuf #(
  parameter logic [8:0] HB_END = 9'd9,
  parameter logic [8:0] HVIS   = 9'd256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       flip,
  input  logic       LHBL,
  input  logic [8:0] h,
  input  logic       buf_we,
  input  logic [8:0] buf_addr,
  input  logic [7:0] buf_din,
  output logic       line_start,
  output logic       clr_busy,
  output logic [7:0] pxl
);

  // Handshake: none. buf_we is a one-clk strobe accepted unconditionally while clr_busy is low;
  // the drawer paces itself from line_start (and, with priority enabled, spaces strobes >= 2 clk).

  logic [7:0] mem [0:1023];

  logic       bank;
  logic       lhbl_l;
  logic [9:0] clr_cnt;
  logic       swap;
  logic [8:0] raddr;
  logic       draw_ok;
  logic [7:0] rd_data;
  logic       er_pend;
  logic [9:0] er_addr;
  logic       er_go;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;

  always_comb begin
    swap    = lhbl_l & ~LHBL;
    raddr   = flip ? (HB_END + HVIS - 9'd1 - h) : (h - HB_END);
    draw_ok = buf_we && (buf_din[3:0] != 4'd0) && !clr_busy;
    // An erase whose bank swapped to the draw side in the meantime is dropped
    er_go   = er_pend && (er_addr[9] == ~bank);
  end

`ifdef JTVIGIL_LBUF_PRIO_EN
  logic       pend_we;
  logic [9:0] pend_addr;
  logic [7:0] pend_din;
  logic [7:0] pend_old;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_we   <= 1'b0;
      pend_addr <= 10'd0;
      pend_din  <= 8'd0;
    end else begin
      pend_we <= draw_ok & ~pend_we;
      if (draw_ok && !pend_we) begin
        pend_addr <= {bank, buf_addr};
        pend_din  <= buf_din;
      end
    end
  end

  // Second clk of a write: only commit if the word has no colour yet
  always_comb begin
    pend_old = mem[pend_addr];
    wr_en    = pend_we && (pend_old[3:0] == 4'd0);
    wr_addr  = pend_addr;
    wr_data  = pend_din;
  end
`else
  always_comb begin
    wr_en   = draw_ok;
    wr_addr = {bank, buf_addr};
    wr_data = buf_din;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bank       <= 1'b0;
      lhbl_l     <= 1'b0;
      line_start <= 1'b0;
      clr_busy   <= 1'b1;
      clr_cnt    <= 10'd0;
    end else begin
      lhbl_l     <= LHBL;
      line_start <= swap;
      if (swap) bank <= ~bank;
      if (clr_busy) begin
        clr_cnt <= clr_cnt + 10'd1;
        if (clr_cnt == 10'd1023) clr_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      er_pend <= 1'b0;
      er_addr <= 10'd0;
      rd_data <= 8'd0;
    end else begin
      er_pend <= pxl_cen && LHBL && !clr_busy;
      if (pxl_cen) begin
        er_addr <= {~bank, raddr};
        rd_data <= mem[{~bank, raddr}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_busy) begin
        mem[clr_cnt] <= 8'd0;
      end else begin
        if (er_go) mem[er_addr] <= 8'd0;
        if (wr_en) mem[wr_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pxl <= 8'd0;
    end else if (!LHBL || clr_busy) begin
      pxl <= 8'd0;
    end else if (pxl_cen) begin
      pxl <= rd_data;
    end
  end

endmodule

// File: tb/tb_jtvigil_obj_lbuf.sv
// Bench for jtvigil_obj_lbuf: drives lines of video timing and compares pixels against a line-buffer model.
module tb_jtvigil_obj_lbuf;

  logic       clk;
  logic       rst;
  logic       pxl_cen;
  logic       flip;
  logic       LHBL;
  logic [8:0] h;
  logic       buf_we;
  logic [8:0] buf_addr;
  logic [7:0] buf_din;
  logic       line_start;
  logic       clr_busy;
  logic [7:0] pxl;

  int total;
  int bad;

  // Model: "nxt" is the line being drawn, "cur" the line being shown
  logic [7:0] cur  [512];
  logic [7:0] nxt  [512];
  logic [7:0] seen [512];
  logic [7:0] exp_q[$];

  jtvigil_obj_lbuf #(.HB_END(9'd9), .HVIS(9'd256)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip(flip), .LHBL(LHBL), .h(h),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din),
    .line_start(line_start), .clr_busy(clr_busy), .pxl(pxl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 512; i++) begin
      cur[i] = 8'd0;
      nxt[i] = 8'd0;
    end
  endtask

  task automatic model_wr(input logic [8:0] a, input logic [7:0] d);
    if (d[3:0] != 4'd0) begin
`ifdef JTVIGIL_LBUF_PRIO_EN
      if (nxt[a][3:0] == 4'd0) nxt[a] = d;
`else
      nxt[a] = d;
`endif
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    buf_addr = a;
    buf_din  = d;
    buf_we   = 1'b1;
    tick;
    buf_we = 1'b0;
    tick;
    tick;
    model_wr(a, d);
  endtask

  task automatic wait_clear;
    int cnt;
    cnt = 0;
    rst = 1'b0;
    while (cnt < 2000) begin
      tick;
      cnt++;
      if (clr_busy === 1'b0) break;
    end
    buf_we = 1'b0;
    total++;
    if (cnt !== 1024) begin
      bad++;
      $display("FAIL clr_len got=%0d exp=1024", cnt);
    end
  endtask

  task automatic do_swap(input logic we, input logic [8:0] a, input logic [7:0] d);
    logic [7:0] tmp;
    if (LHBL !== 1'b1) begin
      LHBL = 1'b1;
      tick;
    end
    LHBL     = 1'b0;
    buf_we   = we;
    buf_addr = a;
    buf_din  = d;
    tick;
    buf_we = 1'b0;
    if (we) model_wr(a, d);
    for (int i = 0; i < 512; i++) begin
      tmp    = cur[i];
      cur[i] = nxt[i];
      nxt[i] = tmp;
    end
    total++;
    if (line_start !== 1'b1) begin
      bad++;
      $display("FAIL line_start_pulse got=%b exp=1", line_start);
    end
    total++;
    if (pxl !== 8'd0) begin
      bad++;
      $display("FAIL pxl_blank got=%h exp=00", pxl);
    end
    tick;
    total++;
    if (line_start !== 1'b0) begin
      bad++;
      $display("FAIL line_start_width got=%b exp=0", line_start);
    end
    tick;
  endtask

  // Scan h across the visible window; pxl at each pxl_cen shows the previous pixel's address
  task automatic read_line(input logic fl);
    logic [8:0] ra;
    logic [8:0] prev;
    logic [7:0] e;
    flip = fl;
    LHBL = 1'b1;
    exp_q.delete();
    prev = 9'd0;
    for (int k = 0; k <= 256; k++) begin
      h  = 9'(9 + k);
      ra = fl ? 9'(264 - (9 + k)) : 9'(k);
      exp_q.push_back(cur[ra]);
      cur[ra] = 8'd0;
      pxl_cen = 1'b1;
      tick;
      pxl_cen = 1'b0;
      if (k >= 1) begin
        e = exp_q.pop_front();
        seen[prev] = pxl;
        total++;
        if (pxl !== e) begin
          bad++;
          $display("FAIL pxl_line addr=%0d flip=%b got=%h exp=%h", prev, fl, pxl, e);
        end
      end
      prev = ra;
      tick;
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if (line_start !== 1'b0 || pxl !== 8'd0 || clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_vals got=%b/%h/%b exp=0/00/1", line_start, pxl, clr_busy);
    end
  endtask

  task automatic test_clear;
    buf_we   = 1'b1;
    buf_addr = 9'd10;
    buf_din  = 8'h5A;
    wait_clear;
    model_clear;
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    total++;
    if (seen[10] !== 8'd0) begin
      bad++;
      $display("FAIL clear_no_write got=%h exp=00", seen[10]);
    end
  endtask

  task automatic test_write_swap_read;
    wr(9'd10, 8'h23);
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    total++;
    if (seen[10] !== 8'h23) begin
      bad++;
      $display("FAIL write_read got=%h exp=23", seen[10]);
    end
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    total++;
    if (seen[10] !== 8'h00) begin
      bad++;
      $display("FAIL erased got=%h exp=00", seen[10]);
    end
  endtask

  task automatic test_transparency;
    wr(9'd5, 8'h70);
    wr(9'd6, 8'h41);
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    total++;
    if (seen[5] !== 8'h00 || seen[6] !== 8'h41) begin
      bad++;
      $display("FAIL transparent got=%h,%h exp=00,41", seen[5], seen[6]);
    end
  endtask

  task automatic test_flip;
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    wr(9'd0, 8'h11);
    wr(9'd255, 8'h22);
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b1);
    total++;
    if (seen[0] !== 8'h11 || seen[255] !== 8'h22) begin
      bad++;
      $display("FAIL flip got=%h,%h exp=11,22", seen[0], seen[255]);
    end
    flip = 1'b0;
  endtask

  task automatic test_priority;
    logic [7:0] e;
`ifdef JTVIGIL_LBUF_PRIO_EN
    e = 8'h12;
`else
    e = 8'h34;
`endif
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    wr(9'd100, 8'h12);
    wr(9'd100, 8'h34);
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    total++;
    if (seen[100] !== e) begin
      bad++;
      $display("FAIL overlap got=%h exp=%h", seen[100], e);
    end
  endtask

  task automatic test_swap_cycle;
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    do_swap(1'b1, 9'd50, 8'h57);
    read_line(1'b0);
    total++;
    if (seen[50] !== 8'h57) begin
      bad++;
      $display("FAIL swap_cycle_write got=%h exp=57", seen[50]);
    end
  endtask

  task automatic test_random;
    logic [7:0] d;
    for (int l = 0; l < 4; l++) begin
      for (int n = 0; n < 24; n++) begin
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 5) == 0) d[3:0] = 4'd0;
        wr(9'($urandom_range(0, 255)), d);
      end
      do_swap(1'b0, 9'd0, 8'd0);
      read_line(1'($urandom_range(0, 1)));
    end
    flip = 1'b0;
  endtask

  task automatic test_reset_midline;
    wr(9'd30, 8'h99);
    LHBL = 1'b1;
    for (int k = 0; k < 40; k++) begin
      h = 9'(9 + k);
      pxl_cen = 1'b1;
      tick;
      pxl_cen = 1'b0;
      tick;
    end
    rst = 1'b1;
    tick;
    total++;
    if (pxl !== 8'd0 || clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL midline_reset got=%h/%b exp=00/1", pxl, clr_busy);
    end
    LHBL = 1'b0;
    tick;
    wait_clear;
    model_clear;
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    do_swap(1'b0, 9'd0, 8'd0);
    read_line(1'b0);
    total++;
    if (seen[30] !== 8'd0) begin
      bad++;
      $display("FAIL midline_clear got=%h exp=00", seen[30]);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    pxl_cen  = 1'b0;
    flip     = 1'b0;
    LHBL     = 1'b0;
    h        = 9'd0;
    buf_we   = 1'b0;
    buf_addr = 9'd0;
    buf_din  = 8'd0;
    for (int i = 0; i < 512; i++) seen[i] = 8'd0;
    model_clear;
    test_reset;
    test_clear;
    test_write_swap_read;
    test_transparency;
    test_flip;
    test_priority;
    test_swap_cycle;
    test_random;
    test_reset_midline;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
